// File: rtl/switch_debounce_4.sv
// switch_debounce_4: synchronises and independently debounces four raw switches into clean A..D levels.
module switch_debounce_4 #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [3:0] code,
  output logic       changed
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic [3:0] synced, stable, stable_nxt;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  assign synced = sync[SYNC_STAGES-1];
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (synced[i] != stable[i]) begin
        if (cnt[i] >= LAST) stable_nxt[i] = synced[i];
        else cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '{default: '0};
      stable  <= '0;
      changed <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], sw_raw};
      cnt     <= cnt_nxt;
      stable  <= stable_nxt;
      changed <= |(stable ^ stable_nxt);
    end
  end
  assign {A, B, C, D} = stable;
  assign code = stable;
endmodule

// File: tb/tb_switch_debounce_4.sv
// tb_switch_debounce_4: randomized and directed stimulus checked against a sliding-window debounce model.
module tb_switch_debounce_4;
  localparam int S  = 2;
  localparam int DC = 8;
  logic clk = 0, rst_n = 0;
  logic [3:0] sw_raw = 4'b1111;
  logic A, B, C, D, changed;
  logic [3:0] code;
  int n_chk = 0, n_fail = 0, pulses = 0;
  logic [3:0] rh [$];
  logic [3:0] win [$];
  logic [3:0] m_stable;
  logic m_changed;

  switch_debounce_4 #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .A(A), .B(B), .C(C), .D(D), .code(code), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    rh = {};
    win = {};
    repeat (S) rh.push_back(4'b0);
    repeat (DC) win.push_back(4'b0);
    m_stable = '0;
    m_changed = 1'b0;
  endtask

  // A channel accepts a level once the debouncer has seen it differ from the
  // stable value on each of the last DC edges; the debouncer sees raw S edges late.
  task automatic tick(input logic [3:0] v);
    logic [3:0] del, fl;
    sw_raw = v;
    @(posedge clk);
    del = rh.pop_front();
    rh.push_back(v);
    win.push_back(del);
    void'(win.pop_front());
    fl = '0;
    for (int c = 0; c < 4; c++) begin
      fl[c] = 1'b1;
      foreach (win[j]) if (win[j][c] == m_stable[c]) fl[c] = 1'b0;
    end
    m_changed = |fl;
    m_stable ^= fl;
    #1;
    check("code", code, m_stable);
    check("abcd", {A, B, C, D}, m_stable);
    check("changed", changed, m_changed);
    if (changed) pulses++;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 0;
    #1;
    check("rst_code", code, 0);
    check("rst_changed", changed, 0);
    model_reset();
    #1 rst_n = 1;
  endtask

  initial begin
    logic [3:0] v;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_code", code, 0);
    check("init_changed", changed, 0);
    rst_n = 1;
    pulses = 0;
    repeat (15) tick(4'b1111);
    check("t1_pulses", pulses, 1);
    repeat (12) tick(4'b0000);
    pulses = 0;
    repeat (14) tick(4'b1010);
    check("t2_pulses", pulses, 1);
    repeat (12) tick(4'b0000);
    pulses = 0;
    repeat (4) begin
      repeat (5) tick(4'b0001);
      repeat (3) tick(4'b0000);
    end
    check("t3_bounce_pulses", pulses, 0);
    check("t3_bounce_code", code, 0);
    repeat (12) tick(4'b0001);
    check("t3_hold_pulses", pulses, 1);
    repeat (12) tick(4'b0000);
    pulses = 0;
    repeat (3) tick(4'b1000);
    repeat (14) tick(4'b1001);
    check("t4_pulses", pulses, 2);
    repeat (12) tick(4'b0000);
    repeat (5) tick(4'b0100);
    pulse_reset();
    repeat (12) tick(4'b0100);
    check("t5_code", code, 4'b0100);
    repeat (12) tick(4'b0000);
    pulses = 0;
    for (int c = 1; c < 16; c++) repeat (20) tick(4'(c));
    check("t6_pulses", pulses, 15);
    v = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
      if ($urandom_range(0, 299) == 0) pulse_reset();
      tick(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_debounce_4.md
Name: switch_debounce_4

Overview:
Upstream input stage for the 4-input combinational logic blocks (A, B, C, D → OUT). It takes four raw board switches, synchronises each one into the clock domain, and debounces each channel independently. It then presents clean, glitch-free A/B/C/D levels, plus a packed code and a one-cycle change strobe. Its outputs connect directly to the A..D inputs of the downstream logic block.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel; must be ≥2.
DEBOUNCE_CYCLES, 500000, consecutive clocks a new synchronised level must hold before it is accepted (10 ms at 50 MHz); must be ≥1.
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk      input   1  single clock; all state updates on rising edge
rst_n    input   1  asynchronous, active-low reset
sw_raw   input   4  raw switch levels, asynchronous to clk; bit3=A, bit2=B, bit1=C, bit0=D
A        output  1  debounced channel 3
B        output  1  debounced channel 2
C        output  1  debounced channel 1
D        output  1  debounced channel 0
code     output  4  {A,B,C,D}; always equal to the individual outputs
changed  output  1  one-cycle pulse when any output bit updates

Behaviour:
- Reset: rst_n low clears everything immediately, without waiting for a clock edge.
  - Cleared: all synchroniser flops, all counters, stable levels, changed.
  - Output values during reset: A=B=C=D=0, code=4'b0000, changed=0.
- Reset release: no changed pulse occurs on the release itself, even when sw_raw≠0. A nonzero sw_raw is then debounced normally.
- Synchroniser: each channel is a chain of SYNC_STAGES flops. sync[0] samples sw_raw. The last stage is the "synced" level.
- Debounce, per channel, evaluated each edge:
  - If synced == stable: cnt ← 0.
  - If synced ≠ stable and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - If synced ≠ stable and cnt == DEBOUNCE_CYCLES-1: stable ← synced, cnt ← 0.
- Latency: a clean raw step is first sampled at edge k. The output changes at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1. There is no early or partial update.
- Glitch rejection: a synced deviation shorter than DEBOUNCE_CYCLES consecutive cycles resets the counter when it returns and never reaches the outputs. Counts are consecutive only, never cumulative.
- Channel independence: each channel has its own counter. A change on one channel never restarts or delays another channel.
- changed:
  - Registered; high for exactly the cycle following any edge where at least one stable bit flips.
  - If several channels flip on the same edge, only one pulse is produced.
  - Flips on consecutive edges produce changed held high for consecutive cycles, one cycle per flipping edge.
- DEBOUNCE_CYCLES=1: each output follows its synced level one edge later.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count: all counts are discarded. Debouncing restarts from zero after release.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, CNT_W=4.
1. Reset check: rst_n=0 with sw_raw=4'b1111 → code=0000, changed=0. Release at edge 0 → code=1111 at edge 9 with a single changed pulse; changed=0 on the release edge.
2. Clean step: code stable at 0000; sw_raw→1010 sampled at edge k → A=1, C=1, code=1010 exactly at edge k+9. One changed cycle; code unchanged on all earlier edges.
3. Bounce rejection: D toggles high 5 cycles, low 3 cycles, repeated 4 times → D and code stay 0, no changed pulse. D then holds high 8 cycles → D=1 and one changed pulse.
4. Independent channels: A rises at edge k, D rises at edge k+3 → A updates at edge k+9, D at edge k+12. Two distinct changed pulses.
5. Async reset mid-count: sw_raw=0100 held 5 cycles, then rst_n pulsed low between edges → outputs 0 immediately. After release with sw_raw=0100, B rises 9 edges after the first post-release sampling edge.
6. Full sweep: sw_raw steps 0000→1111 in binary order, 20 cycles per code → code matches each value 9 cycles after its step. Exactly 15 changed pulses; no intermediate codes appear on code.
